// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the pointer-crossing receiver.
// Helpers work on a wide zero-extended word; callers size-cast back to N bits.
package gray_pkg;

  localparam int GW = 32;

  typedef logic [GW-1:0] gword_t;

  typedef enum logic [1:0] {
    FILL,
    FIRST,
    RUN
  } state_e;

  // Zero-extension is harmless: leading zeros leave every lower bit unchanged.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  // More than one bit set iff clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input gword_t x);
    return (x & (x - gword_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus; q is the last stage.
// Ports: clk, rst (async high), d (foreign-domain input), q (synchronised).
module gray_sync_chain #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] s_q [SYNC_STAGES];
  logic [N-1:0] s_d [SYNC_STAGES];

  always_comb begin
    s_d[0] = d;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      s_d[k] = s_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        s_q[k] <= s_d[k];
      end
    end
  end

  assign q = s_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receives a Gray pointer from another domain, decodes it, reports delta/errors.
// Ports: clk, rst, gray_in, clr_err -> bin_out, bin_valid, delta, err, err_count.
module gray_ptr_receiver
  import gray_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         gray_in,
  input  logic                 clr_err,
  output logic [N-1:0]         bin_out,
  output logic                 bin_valid,
  output logic [N-1:0]         delta,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [N-1:0] gs;

  gray_sync_chain #(
    .N          (N),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (gray_in),
    .q  (gs)
  );

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         prev_gs_q, prev_gs_d;
  logic [N-1:0]         bin_out_q, bin_out_d;
  logic [N-1:0]         delta_q, delta_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [N-1:0] dec;
  logic         err_evt;

  assign dec = N'(gray2bin(gword_t'(gs)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_gs_d = prev_gs_q;
    bin_out_d = bin_out_q;
    delta_d   = delta_q;
    valid_d   = valid_q;
    err_evt   = 1'b0;

    unique case (state_q)
      FILL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SYNC_STAGES - 1)) begin
          state_d = FIRST;
        end
      end
      FIRST: begin
        bin_out_d = dec;
        delta_d   = '0;
        valid_d   = 1'b1;
        prev_gs_d = gs;
        state_d   = RUN;
      end
      RUN: begin
        bin_out_d = dec;
        delta_d   = dec - bin_out_q;
        prev_gs_d = gs;
        err_evt   = popcount_gt1(gword_t'(gs ^ prev_gs_q));
      end
      default: state_d = FILL;
    endcase
  end

  // An error on the clearing edge restarts the count at one.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (err_evt) begin
      err_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = ERR_CNT_W'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      prev_gs_q <= '0;
      bin_out_q <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_gs_q <= prev_gs_d;
      bin_out_q <= bin_out_d;
      delta_q   <= delta_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = valid_q;
  assign delta     = delta_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule
